// File: rtl/simon_input_conditioner_if.sv
// Signal bundle between the board-side raw controls and the Simon core inputs.
// The conditioner is the slave: it takes in raw button/switches and drives the clean outputs.
interface simon_input_conditioner_if;
    logic       btn_raw;
    logic [3:0] sw_pattern;
    logic       sw_level;
    logic       pclk;
    logic [3:0] pattern;
    logic       level;
    logic       press;

    modport master (
        output btn_raw, sw_pattern, sw_level,
        input  pclk, pattern, level, press
    );

    modport slave (
        input  btn_raw, sw_pattern, sw_level,
        output pclk, pattern, level, press
    );
endinterface

// File: rtl/simon_input_conditioner.sv
// Synchronizes and debounces the board button and switches, then emits one glitch-free
// pclk pulse per press with pattern/level frozen around it (setup before, hold after).
module simon_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    simon_input_conditioner_if.slave   io
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic          btn_meta, btn_sync;
    logic [4:0]    sw_meta, sw_sync;
    logic          btn_db, btn_db_q;
    logic [DW-1:0] btn_cnt;
    logic [4:0]    sw_db, sw_cand;
    logic [DW-1:0] sw_cnt;
    logic          press_r;
    logic [1:0]    state;
    logic [PW-1:0] pcnt;
    logic          pclk_r;
    logic [3:0]    pattern_r;
    logic          level_r;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values,
    // which is what makes the two synchronizer stages a real two-flop chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= io.btn_raw;
            btn_sync <= btn_meta;
            sw_meta  <= {io.sw_level, io.sw_pattern};
            sw_sync  <= sw_meta;
        end
    end

    // Button: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db  <= 1'b0;
            btn_cnt <= '0;
        end else if (btn_sync == btn_db) begin
            btn_cnt <= '0;
        end else if (btn_cnt >= DB_LAST) begin
            btn_db  <= btn_sync;
            btn_cnt <= '0;
        end else begin
            btn_cnt <= btn_cnt + DW'(1);
        end
    end

    // Switches: one counter for the whole vector; a new candidate restarts the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_db   <= '0;
            sw_cand <= '0;
            sw_cnt  <= '0;
        end else if (sw_sync == sw_db) begin
            sw_cand <= sw_db;
            sw_cnt  <= '0;
        end else if (sw_sync != sw_cand) begin
            sw_cand <= sw_sync;
            sw_cnt  <= DW'(1);
        end else if (sw_cnt >= DB_LAST) begin
            sw_db   <= sw_cand;
            sw_cnt  <= '0;
        end else begin
            sw_cnt  <= sw_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db_q <= 1'b0;
            press_r  <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            press_r  <= btn_db & ~btn_db_q;
        end
    end

    // Pulse sequencer: outputs are registered so pclk never glitches; presses outside IDLE are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pcnt      <= '0;
            pclk_r    <= 1'b0;
            pattern_r <= '0;
            level_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pattern_r <= sw_db[3:0];
                    level_r   <= sw_db[4];
                    pclk_r    <= 1'b0;
                    if (press_r) state <= ST_SETUP;
                end
                ST_SETUP: begin
                    state  <= ST_HIGH;
                    pclk_r <= 1'b1;
                    pcnt   <= P_LAST;
                end
                ST_HIGH: begin
                    if (pcnt == '0) begin
                        state  <= ST_HOLD;
                        pclk_r <= 1'b0;
                        pcnt   <= P_LAST;
                    end else begin
                        pcnt <= pcnt - PW'(1);
                    end
                end
                ST_HOLD: begin
                    if (pcnt == '0) state <= ST_IDLE;
                    else            pcnt  <= pcnt - PW'(1);
                end
                default: begin
                    state  <= ST_IDLE;
                    pclk_r <= 1'b0;
                end
            endcase
        end
    end

    assign io.pclk    = pclk_r;
    assign io.pattern = pattern_r;
    assign io.level   = level_r;
    assign io.press   = press_r;

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Directed bench for simon_input_conditioner: a D=16/P=4 instance for reset, press timing,
// bounce, freeze and mid-pulse reset, plus a D=4/P=16 instance where a re-press can land in HOLD.
module tb_simon_input_conditioner;

    logic clk;
    logic rst;

    simon_input_conditioner_if m_if ();
    simon_input_conditioner_if f_if ();

    simon_input_conditioner #(.DEBOUNCE_CYCLES(16), .PULSE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (m_if)
    );

    simon_input_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(16)) dut_fast (
        .clk (clk),
        .rst (rst),
        .io  (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    int m_press = 0, m_rise = 0, m_hi = 0;
    int f_press = 0, f_rise = 0;

    always @(posedge clk) begin
        if (m_if.press === 1'b1) m_press++;
        if (m_if.pclk === 1'b1)  m_hi++;
        if (f_if.press === 1'b1) f_press++;
    end
    always @(posedge m_if.pclk) m_rise++;
    always @(posedge f_if.pclk) f_rise++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int p0, r0, h0;

    initial begin
        // Reset with button pressed and all pattern switches on
        rst = 1'b0;
        m_if.btn_raw = 1'b1; m_if.sw_pattern = 4'hF; m_if.sw_level = 1'b0;
        f_if.btn_raw = 1'b0; f_if.sw_pattern = 4'h0; f_if.sw_level = 1'b0;
        step(3);
        check("rst_pclk",    8'(m_if.pclk),    8'h0);
        check("rst_press",   8'(m_if.press),   8'h0);
        check("rst_pattern", 8'(m_if.pattern), 8'h0);
        check("rst_level",   8'(m_if.level),   8'h0);
        check("rst_fast_pclk", 8'(f_if.pclk),  8'h0);

        m_if.btn_raw = 1'b0; m_if.sw_pattern = 4'h1; rst = 1'b1;
        step(5);
        check("post_rst_pclk",  8'(m_if.pclk),  8'h0);
        check("post_rst_press", 8'(m_if.press), 8'h0);
        step(13);
        check("sw_lat_e18_pattern", 8'(m_if.pattern), 8'h0);
        step(1);
        check("sw_lat_e19_pattern", 8'(m_if.pattern), 8'h1);
        check("sw_lat_e19_level",   8'(m_if.level),   8'h0);

        // Clean press, held 60 cycles
        step(5);
        p0 = m_press; r0 = m_rise; h0 = m_hi;
        m_if.btn_raw = 1'b1;
        step(18);
        check("clean_press_e18", 8'(m_if.press), 8'h0);
        step(1);
        check("clean_press_e19", 8'(m_if.press), 8'h1);
        check("clean_pclk_e19",  8'(m_if.pclk),  8'h0);
        step(1);
        check("clean_press_e20",   8'(m_if.press),   8'h0);
        check("clean_pclk_e20",    8'(m_if.pclk),    8'h0);
        check("clean_pattern_e20", 8'(m_if.pattern), 8'h1);
        step(1);
        check("clean_pclk_e21", 8'(m_if.pclk), 8'h1);
        step(3);
        check("clean_pclk_e24", 8'(m_if.pclk), 8'h1);
        step(1);
        check("clean_pclk_e25",    8'(m_if.pclk),    8'h0);
        check("clean_pattern_e25", 8'(m_if.pattern), 8'h1);
        step(4);
        check("clean_pattern_e29", 8'(m_if.pattern), 8'h1);
        check("clean_pclk_e29",    8'(m_if.pclk),    8'h0);
        step(31);
        check("clean_press_count", 8'(m_press - p0), 8'd1);
        check("clean_pclk_rises",  8'(m_rise - r0),  8'd1);
        check("clean_pclk_width",  8'(m_hi - h0),    8'd4);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed
        m_if.btn_raw = 1'b0;
        step(25);
        p0 = m_press; r0 = m_rise; h0 = m_hi;
        for (int i = 0; i < 10; i++) begin
            m_if.btn_raw = ~m_if.btn_raw;
            step(3);
        end
        check("bounce_no_press", 8'(m_press - p0), 8'd0);
        check("bounce_no_pclk",  8'(m_rise - r0),  8'd0);
        m_if.btn_raw = 1'b1;
        step(60);
        check("bounce_press_count", 8'(m_press - p0), 8'd1);
        check("bounce_pclk_rises",  8'(m_rise - r0),  8'd1);
        check("bounce_pclk_width",  8'(m_hi - h0),    8'd4);

        // Freeze: switches move two cycles after pclk rises
        m_if.btn_raw = 1'b0;
        step(25);
        m_if.btn_raw = 1'b1;
        step(21);
        check("freeze_pclk_e21", 8'(m_if.pclk), 8'h1);
        step(2);
        check("freeze_pattern_e23", 8'(m_if.pattern), 8'h1);
        m_if.sw_pattern = 4'h8; m_if.sw_level = 1'b1;
        step(6);
        check("freeze_pattern_e29", 8'(m_if.pattern), 8'h1);
        check("freeze_level_e29",   8'(m_if.level),   8'h0);
        step(12);
        check("freeze_pattern_e41", 8'(m_if.pattern), 8'h1);
        check("freeze_level_e41",   8'(m_if.level),   8'h0);
        step(1);
        check("freeze_pattern_e42", 8'(m_if.pattern), 8'h8);
        check("freeze_level_e42",   8'(m_if.level),   8'h1);

        // Drop/repress on the D=4, P=16 instance: second press lands in HOLD
        p0 = f_press; r0 = f_rise;
        f_if.btn_raw = 1'b1;
        step(9);
        check("drop_pclk_e9", 8'(f_if.pclk), 8'h1);
        step(1);
        f_if.btn_raw = 1'b0;
        step(10);
        f_if.btn_raw = 1'b1;
        step(30);
        check("drop_press_seen",     8'(f_press - p0), 8'd2);
        check("drop_no_second_pclk", 8'(f_rise - r0),  8'd1);
        check("drop_pclk_e50",       8'(f_if.pclk),    8'h0);
        f_if.btn_raw = 1'b0;
        step(10);
        f_if.btn_raw = 1'b1;
        step(10);
        check("repress_pclk_e70", 8'(f_if.pclk), 8'h1);
        step(20);
        check("repress_pclk_rises", 8'(f_rise - r0), 8'd2);
        check("repress_pclk_e90",   8'(f_if.pclk),   8'h0);

        // Mid-pulse reset two cycles into HIGH
        m_if.btn_raw = 1'b0;
        step(25);
        m_if.btn_raw = 1'b1;
        step(23);
        check("mid_pclk_e23", 8'(m_if.pclk), 8'h1);
        r0 = m_rise;
        rst = 1'b0;
        #1;
        check("mid_rst_pclk",    8'(m_if.pclk),    8'h0);
        check("mid_rst_press",   8'(m_if.press),   8'h0);
        check("mid_rst_pattern", 8'(m_if.pattern), 8'h0);
        check("mid_rst_level",   8'(m_if.level),   8'h0);
        step(2);
        m_if.btn_raw = 1'b0;
        rst = 1'b1;
        step(3);
        check("mid_post_pclk",    8'(m_if.pclk),    8'h0);
        check("mid_post_pattern", 8'(m_if.pattern), 8'h0);
        step(40);
        check("mid_post_no_pclk",  8'(m_rise - r0),   8'd0);
        check("mid_post_pattern2", 8'(m_if.pattern),  8'h8);
        check("mid_post_level2",   8'(m_if.level),    8'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
